// File: rtl/bus_interval_timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// CONTROL/STATUS bit positions, FSM encoding and the decoded bus command.
package bus_interval_timer_pkg;

  localparam logic [3:0] BASE_DEFAULT = 4'h3;

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_CONTROL = 3'd1;
  localparam logic [2:0] OFF_PERL    = 3'd2;
  localparam logic [2:0] OFF_PERH    = 3'd3;
  localparam logic [2:0] OFF_SNAPL   = 3'd4;
  localparam logic [2:0] OFF_SNAPH   = 3'd5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

  localparam logic ST_STOPPED = 1'b0;
  localparam logic ST_RUNNING = 1'b1;

  // Side effects of one decoded bus write, resolved for the current edge.
  typedef struct packed {
    logic start;
    logic stop;
    logic to_clr;
    logic snap;
  } tmr_cmd_t;

endpackage

// File: rtl/bus_interval_timer_count.sv
// 32-bit down counter: load L has priority over decrement enable E; Z flags zero.
module tmr_count
  import bus_interval_timer_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        L,
  input  logic        E,
  input  logic [31:0] D,
  output logic [31:0] C,
  output logic        Z
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      C <= RST_VAL;
    end else if (L) begin
      C <= D;
    end else if (E) begin
      C <= C - 32'd1;
    end
  end

  assign Z = (C == 32'd0);

endmodule

// File: rtl/bus_interval_timer.sv
// Interval timer slave on the processor ADDR/DOUT/W bus. Read data is registered
// so it lines up with the synchronous memory's one-cycle read latency.
module bus_interval_timer
  import bus_interval_timer_pkg::*;
#(
  parameter logic [3:0]  BASE    = BASE_DEFAULT,
  parameter logic [31:0] RST_PER = 32'd0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] Q,
  output logic        Q_sel,
  output logic        IRQ
);

  logic        sel;
  logic        wr;
  logic [2:0]  off;
  logic        ctl_wr;
  logic        cont_eff;
  tmr_cmd_t    cmd;

  logic        state;
  logic        state_nx;
  logic        to;
  logic        to_set;
  logic        ito;
  logic        cont;
  logic [31:0] period;
  logic [31:0] snap;
  logic [31:0] count;
  logic        cnt_zero;
  logic        cnt_load;
  logic        cnt_en;
  logic [15:0] rd_data;
  logic        unused_addr;

  assign sel         = (ADDR[15:12] == BASE);
  assign off         = ADDR[2:0];
  assign wr          = sel & W;
  assign unused_addr = ^ADDR[11:3];

  assign ctl_wr     = wr && (off == OFF_CONTROL);
  assign cmd.stop   = ctl_wr & DOUT[CTL_STOP];
  assign cmd.start  = ctl_wr & DOUT[CTL_START] & ~DOUT[CTL_STOP];
  assign cmd.to_clr = wr && (off == OFF_STATUS);
  assign cmd.snap   = wr && ((off == OFF_SNAPL) || (off == OFF_SNAPH));
  // A CONT value written on this edge already governs a timeout on this edge.
  assign cont_eff   = ctl_wr ? DOUT[CTL_CONT] : cont;

  tmr_count #(
    .RST_VAL(RST_PER)
  ) u_count (
    .Clock (Clock),
    .Resetn(Resetn),
    .L     (cnt_load),
    .E     (cnt_en),
    .D     (period),
    .C     (count),
    .Z     (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    to_set   = 1'b0;
    case (state)
      ST_STOPPED: begin
        if (cmd.start) begin
          cnt_load = 1'b1;
          state_nx = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (cmd.stop) begin
          state_nx = ST_STOPPED;
        end else if (cmd.start) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          to_set   = 1'b1;
          cnt_load = 1'b1;
          if (!cont_eff) state_nx = ST_STOPPED;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_nx = ST_STOPPED;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= ST_STOPPED;
      to     <= 1'b0;
      ito    <= 1'b0;
      cont   <= 1'b0;
      period <= RST_PER;
      snap   <= 32'd0;
    end else begin
      state <= state_nx;
      // Set beats a clear landing on the same edge.
      to    <= to_set | (to & ~cmd.to_clr);
      if (ctl_wr) begin
        ito  <= DOUT[CTL_ITO];
        cont <= DOUT[CTL_CONT];
      end
      if (wr && (off == OFF_PERL)) period[15:0]  <= DOUT;
      if (wr && (off == OFF_PERH)) period[31:16] <= DOUT;
      if (cmd.snap) snap <= count;
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    case (off)
      OFF_STATUS: begin
        rd_data[STS_TO]  = to;
        rd_data[STS_RUN] = (state == ST_RUNNING);
      end
      OFF_CONTROL: begin
        rd_data[CTL_ITO]  = ito;
        rd_data[CTL_CONT] = cont;
      end
      OFF_PERL:  rd_data = period[15:0];
      OFF_PERH:  rd_data = period[31:16];
      OFF_SNAPL: rd_data = snap[15:0];
      OFF_SNAPH: rd_data = snap[31:16];
      default:   rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Q     <= 16'h0000;
      Q_sel <= 1'b0;
    end else begin
      Q     <= sel ? rd_data : 16'h0000;
      Q_sel <= sel;
    end
  end

  assign IRQ = to & ito;

endmodule

// File: tb/tb_bus_interval_timer.sv
// Bench for bus_interval_timer: timeout instants, sticky status and snapshots are
// predicted from period arithmetic (timeouts every PERIOD+1 edges after START).
module tb_bus_interval_timer;

  localparam logic [2:0] O_STATUS = 3'd0;
  localparam logic [2:0] O_CONTROL = 3'd1;
  localparam logic [2:0] O_PERL = 3'd2;
  localparam logic [2:0] O_PERH = 3'd3;
  localparam logic [2:0] O_SNAPL = 3'd4;
  localparam logic [2:0] O_SNAPH = 3'd5;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] ADDR = 16'h0;
  logic [15:0] DOUT = 16'h0;
  logic        W = 1'b0;
  logic [15:0] Q;
  logic        Q_sel;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;

  bus_interval_timer #(.BASE(4'h3), .RST_PER(32'd0)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
    .Q(Q), .Q_sel(Q_sel), .IRQ(IRQ)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All bus tasks start at a falling edge and return at the next falling edge.
  task automatic bus_wr(input logic [2:0] off, input logic [15:0] d);
    ADDR = {4'h3, 9'h000, off}; DOUT = d; W = 1'b1;
    @(negedge Clock);
    W = 1'b0; ADDR = 16'h0; DOUT = 16'h0;
  endtask

  task automatic bus_rd(input logic [2:0] off, output logic [15:0] d);
    ADDR = {4'h3, 9'h000, off}; W = 1'b0;
    @(negedge Clock);
    d = Q; ADDR = 16'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic set_period(input logic [31:0] p);
    bus_wr(O_PERL, p[15:0]);
    bus_wr(O_PERH, p[31:16]);
  endtask

  task automatic test_reset;
    logic [15:0] rd;
    int k;
    W = 1'b0; ADDR = 16'h0; DOUT = 16'h0; Resetn = 1'b0;
    idle(3);
    Resetn = 1'b1;
    idle(1);
    n_cmp++; if (Q !== 16'h0 || Q_sel !== 1'b0 || IRQ !== 1'b0) begin n_err++;
      $display("FAIL reset_outputs: got Q=%h Q_sel=%b IRQ=%b want 0/0/0", Q, Q_sel, IRQ); end
    bus_rd(O_STATUS, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_status: got %h want 0000", rd); end
    bus_rd(O_PERL, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_perl: got %h want 0000", rd); end
    // Run with PERIOD=7, then pull reset while COUNT sits at 5.
    set_period(32'd7);
    bus_wr(O_CONTROL, 16'h0007);
    k = 0;
    while (IRQ !== 1'b1 && k < 100) begin @(negedge Clock); k++; end
    n_cmp++; if (k !== 8) begin n_err++; $display("FAIL reset_prerun_timeout: got %0d want 8", k); end
    idle(2);
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL reset_prerun_irq: got %b want 1", IRQ); end
    #2 Resetn = 1'b0;
    #1;
    n_cmp++; if (IRQ !== 1'b0 || Q !== 16'h0 || Q_sel !== 1'b0) begin n_err++;
      $display("FAIL reset_async: got IRQ=%b Q=%h Q_sel=%b want 0/0/0", IRQ, Q, Q_sel); end
    @(negedge Clock);
    Resetn = 1'b1;
    idle(1);
    bus_rd(O_STATUS, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_status_after: got %h want 0000", rd); end
    bus_rd(O_CONTROL, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_control_after: got %h want 0000", rd); end
    bus_wr(O_SNAPL, 16'h0);
    bus_rd(O_SNAPL, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_count_l: got %h want 0000", rd); end
    bus_rd(O_PERL, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_period_l: got %h want 0000", rd); end
  endtask

  task automatic test_one_shot;
    logic [15:0] rd;
    int p, k;
    for (int i = 0; i < 5; i++) begin
      p = (i == 0) ? 3 : int'($urandom_range(0, 40));
      bus_wr(O_STATUS, 16'h0);
      set_period(p);
      bus_wr(O_CONTROL, 16'h0004);
      idle(p);
      bus_rd(O_STATUS, rd);
      n_cmp++; if (rd !== 16'h0002) begin n_err++; $display("FAIL one_shot_before p=%0d: got %h want 0002", p, rd); end
      bus_rd(O_STATUS, rd);
      n_cmp++; if (rd !== 16'h0001) begin n_err++; $display("FAIL one_shot_after p=%0d: got %h want 0001", p, rd); end
      idle(p + 2);
      bus_rd(O_STATUS, rd);
      n_cmp++; if (rd !== 16'h0001 || IRQ !== 1'b0) begin n_err++;
        $display("FAIL one_shot_hold p=%0d: got %h irq=%b want 0001 irq=0", p, rd, IRQ); end
    end
    bus_wr(O_CONTROL, 16'h0001);
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL one_shot_ito_irq: got %b want 1", IRQ); end
    bus_wr(O_STATUS, 16'hFFFF);
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL one_shot_clear_irq: got %b want 0", IRQ); end
    for (int i = 0; i < 4; i++) begin
      p = int'($urandom_range(0, 30));
      set_period(p);
      bus_wr(O_CONTROL, 16'h0005);
      k = 0;
      while (IRQ !== 1'b1 && k < 200) begin @(negedge Clock); k++; end
      n_cmp++; if (k !== p + 1) begin n_err++; $display("FAIL one_shot_irq_delay p=%0d: got %0d want %0d", p, k, p + 1); end
      bus_wr(O_STATUS, 16'h0);
    end
  endtask

  task automatic test_continuous;
    logic [15:0] rd;
    int p, nk;
    logic clr, to_exp;
    for (int i = 0; i < 4; i++) begin
      p = (i == 0) ? 9 : (i == 1) ? 0 : int'($urandom_range(1, 12));
      bus_wr(O_STATUS, 16'h0);
      set_period(p);
      bus_wr(O_CONTROL, 16'h0007);
      to_exp = 1'b0;
      nk = 4 * (p + 1) + 2;
      for (int k = 1; k <= nk; k++) begin
        clr = (k == 2 * (p + 1)) || ($urandom_range(0, 3) == 0);
        if (clr) begin ADDR = 16'h3000; DOUT = 16'($urandom); W = 1'b1; end
        @(negedge Clock);
        W = 1'b0; ADDR = 16'h0;
        to_exp = ((k % (p + 1)) == 0) | (to_exp & ~clr);
        n_cmp++; if (IRQ !== to_exp) begin n_err++;
          $display("FAIL cont_irq p=%0d k=%0d: got %b want %b", p, k, IRQ, to_exp); end
      end
      bus_rd(O_STATUS, rd);
      n_cmp++; if (rd[1] !== 1'b1) begin n_err++; $display("FAIL cont_run p=%0d: got %h want RUN=1", p, rd); end
      bus_wr(O_CONTROL, 16'h000B);
      bus_wr(O_STATUS, 16'h0);
      idle(p + 3);
      bus_rd(O_STATUS, rd);
      n_cmp++; if (rd !== 16'h0000 || IRQ !== 1'b0) begin n_err++;
        $display("FAIL cont_stopped p=%0d: got %h irq=%b want 0000 irq=0", p, rd, IRQ); end
    end
  endtask

  task automatic test_period_update;
    int p1, p2, d, k;
    for (int i = 0; i < 3; i++) begin
      p1 = int'($urandom_range(4, 20));
      p2 = int'($urandom_range(1, 20));
      d = int'($urandom_range(0, p1 - 1));
      bus_wr(O_STATUS, 16'h0);
      set_period(p1);
      bus_wr(O_CONTROL, 16'h0007);
      idle(d);
      bus_wr(O_PERL, 16'(p2));
      k = d + 1;
      while (IRQ !== 1'b1 && k < 200) begin @(negedge Clock); k++; end
      n_cmp++; if (k !== p1 + 1) begin n_err++; $display("FAIL perupd_first: got %0d want %0d", k, p1 + 1); end
      bus_wr(O_STATUS, 16'h0);
      k++;
      while (IRQ !== 1'b1 && k < 300) begin @(negedge Clock); k++; end
      n_cmp++; if (k !== p1 + p2 + 2) begin n_err++; $display("FAIL perupd_second: got %0d want %0d", k, p1 + p2 + 2); end
      bus_wr(O_CONTROL, 16'h0008);
      bus_wr(O_STATUS, 16'h0);
    end
    for (int i = 0; i < 3; i++) begin
      p1 = int'($urandom_range(5, 20));
      d = int'($urandom_range(0, p1 - 1));
      set_period(p1);
      bus_wr(O_CONTROL, 16'h0005);
      idle(d);
      bus_wr(O_CONTROL, 16'h0005);
      k = 0;
      while (IRQ !== 1'b1 && k < 200) begin @(negedge Clock); k++; end
      n_cmp++; if (k !== p1 + 1) begin n_err++; $display("FAIL restart_delay p=%0d: got %0d want %0d", p1, k, p1 + 1); end
      bus_wr(O_STATUS, 16'h0);
    end
  endtask

  task automatic test_snapshot;
    logic [15:0] lo, hi;
    logic [31:0] p, exp_v;
    int d;
    set_period(32'h0001_0005);
    bus_wr(O_CONTROL, 16'h0004);
    idle(3);
    bus_wr(O_SNAPL, 16'h0);
    bus_rd(O_SNAPH, hi);
    bus_rd(O_SNAPL, lo);
    n_cmp++; if ({hi, lo} !== 32'h0001_0002) begin n_err++; $display("FAIL snap_fixed: got %h want 00010002", {hi, lo}); end
    bus_wr(O_SNAPH, 16'h0);
    bus_rd(O_SNAPL, lo);
    bus_rd(O_SNAPH, hi);
    n_cmp++; if ({hi, lo} !== 32'h0000_FFFF) begin n_err++; $display("FAIL snap_borrow: got %h want 0000ffff", {hi, lo}); end
    bus_wr(O_CONTROL, 16'h0008);
    for (int i = 0; i < 4; i++) begin
      p = 32'h0002_0000 + 32'($urandom_range(0, 16'hFFFF));
      d = int'($urandom_range(0, 20));
      set_period(p);
      bus_wr(O_CONTROL, 16'h0004);
      idle(d);
      bus_wr(($urandom_range(0, 1) == 0) ? O_SNAPL : O_SNAPH, 16'($urandom));
      bus_rd(O_SNAPL, lo);
      bus_rd(O_SNAPH, hi);
      exp_v = p - 32'(d);
      n_cmp++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL snap_rand d=%0d: got %h want %h", d, {hi, lo}, exp_v); end
      bus_wr(O_CONTROL, 16'h0008);
    end
  endtask

  task automatic test_decode;
    logic [15:0] rd;
    bus_wr(O_PERL, 16'h1234);
    bus_wr(O_PERH, 16'h00A5);
    idle(1);
    n_cmp++; if (Q_sel !== 1'b0) begin n_err++; $display("FAIL decode_idle_sel: got %b want 0", Q_sel); end
    ADDR = 16'h3002;
    @(negedge Clock);
    n_cmp++; if (Q !== 16'h1234 || Q_sel !== 1'b1) begin n_err++;
      $display("FAIL decode_read: got Q=%h sel=%b want 1234/1", Q, Q_sel); end
    ADDR = 16'h1002; DOUT = 16'hBEEF; W = 1'b1;
    @(negedge Clock);
    W = 1'b0;
    n_cmp++; if (Q !== 16'h0000 || Q_sel !== 1'b0) begin n_err++;
      $display("FAIL decode_other: got Q=%h sel=%b want 0000/0", Q, Q_sel); end
    for (int i = 0; i < 8; i++) begin
      ADDR = {4'($urandom_range(4, 15)), 12'($urandom)};
      DOUT = 16'($urandom); W = 1'b1;
      @(negedge Clock);
      W = 1'b0;
      n_cmp++; if (Q !== 16'h0000 || Q_sel !== 1'b0) begin n_err++;
        $display("FAIL decode_rand a=%h: got Q=%h sel=%b want 0000/0", ADDR, Q, Q_sel); end
    end
    ADDR = {4'h3, 9'($urandom), 3'd3};
    @(negedge Clock);
    n_cmp++; if (Q !== 16'h00A5) begin n_err++; $display("FAIL decode_alias: got %h want 00a5", Q); end
    ADDR = 16'h0;
    bus_rd(O_PERL, rd);
    n_cmp++; if (rd !== 16'h1234) begin n_err++; $display("FAIL decode_perl_kept: got %h want 1234", rd); end
    bus_rd(O_STATUS, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL decode_status_kept: got %h want 0000", rd); end
    bus_wr(3'd6, 16'hFFFF);
    bus_wr(3'd7, 16'hFFFF);
    bus_rd(3'd6, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL decode_off6: got %h want 0000", rd); end
    bus_rd(3'd7, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL decode_off7: got %h want 0000", rd); end
    bus_wr(O_CONTROL, 16'h0003);
    bus_rd(O_CONTROL, rd);
    n_cmp++; if (rd !== 16'h0003) begin n_err++; $display("FAIL decode_control_rb: got %h want 0003", rd); end
    bus_wr(O_CONTROL, 16'h0000);
  endtask

  task automatic test_conflicts;
    logic [15:0] rd;
    bus_wr(O_STATUS, 16'h0);
    set_period(32'd5);
    bus_wr(O_CONTROL, 16'h000C);
    bus_rd(O_STATUS, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL conflict_stopped: got %h want 0000", rd); end
    bus_rd(O_CONTROL, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL conflict_ctl_rb: got %h want 0000", rd); end
    bus_wr(O_CONTROL, 16'h000D);
    idle(9);
    bus_rd(O_STATUS, rd);
    n_cmp++; if (rd !== 16'h0000 || IRQ !== 1'b0) begin n_err++;
      $display("FAIL conflict_no_run: got %h irq=%b want 0000 irq=0", rd, IRQ); end
    bus_wr(O_CONTROL, 16'h0005);
    idle(1);
    bus_wr(O_CONTROL, 16'h000D);
    idle(10);
    bus_rd(O_STATUS, rd);
    n_cmp++; if (rd !== 16'h0000 || IRQ !== 1'b0) begin n_err++;
      $display("FAIL conflict_stop_running: got %h irq=%b want 0000 irq=0", rd, IRQ); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_continuous();
    test_period_update();
    test_snapshot();
    test_decode();
    test_conflicts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
